// File: rtl/otp_bank_scheduler_if.sv
// Handshake bundle between the OTP bank scheduler, otp_gen and the sd side.
// The slave modport is the scheduler; the master modport drives it.
interface otp_bank_scheduler_if #(
   parameter int CNT_W = 16
);
   logic             istart;
   logic             istop;
   logic             iblock_req;
   logic             oblock_ready;
   logic             ord_bank;
   logic             ogen_start;
   logic             ogen_new;
   logic             igen_done;
   logic             iwrite_en;
   logic             owrite_en0;
   logic             owrite_en1;
   logic [CNT_W-1:0] oblk_cnt;
   logic             ounderrun;

   modport slave (
      input  istart, istop, iblock_req, igen_done, iwrite_en,
      output oblock_ready, ord_bank, ogen_start, ogen_new,
      output owrite_en0, owrite_en1, oblk_cnt, ounderrun
   );

   modport master (
      output istart, istop, iblock_req, igen_done, iwrite_en,
      input  oblock_ready, ord_bank, ogen_start, ogen_new,
      input  owrite_en0, owrite_en1, oblk_cnt, ounderrun
   );
endinterface

// File: rtl/otp_bank_scheduler.sv
// Ping-pong scheduler for two OTP RAM banks: otp_gen fills one bank
// while the sd controller consumes the other.
module otp_bank_scheduler #(
   parameter int CNT_W = 16
) (
   input logic                 iclk,
   input logic                 irst,
   otp_bank_scheduler_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      GEN,
      HOLD,
      DRAIN
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       valid_q, valid_d;
   logic             rd_bank_q, rd_bank_d;
   logic             wr_bank_q, wr_bank_d;
   logic             start_q, start_d;
   logic             new_q, new_d;
   logic             under_q, under_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready;
   logic             accept;
   logic             gen_st;

   assign ready  = valid_q[rd_bank_q];
   assign accept = bus.iblock_req & ready & ~bus.istop;
   assign gen_st = (state_q == GEN);

   assign bus.oblock_ready = ready;
   assign bus.ord_bank     = rd_bank_q;
   assign bus.ogen_start   = start_q;
   assign bus.ogen_new     = new_q;
   assign bus.oblk_cnt     = cnt_q;
   assign bus.ounderrun    = under_q;
   assign bus.owrite_en0   = bus.iwrite_en & gen_st & ~wr_bank_q;
   assign bus.owrite_en1   = bus.iwrite_en & gen_st & wr_bank_q;

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      rd_bank_d = rd_bank_q;
      wr_bank_d = wr_bank_q;
      cnt_d     = cnt_q;
      under_d   = under_q;
      start_d   = 1'b0;
      new_d     = 1'b0;

      if (bus.iblock_req & ~ready & ~bus.istop) begin
         under_d = 1'b1;
      end
      if (accept) begin
         valid_d[rd_bank_q] = 1'b0;
         rd_bank_d          = ~rd_bank_q;
         cnt_d              = cnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (bus.istart & ~bus.istop) begin
               valid_d   = 2'b00;
               rd_bank_d = 1'b0;
               wr_bank_d = 1'b0;
               cnt_d     = '0;
               under_d   = 1'b0;
               start_d   = 1'b1;
               state_d   = GEN;
            end
         end
         GEN: begin
            if (bus.istop) begin
               valid_d = 2'b00;
               state_d = DRAIN;
            end else if (bus.igen_done) begin
               valid_d[wr_bank_q] = 1'b1;
               // a bank freed this same cycle counts as empty
               if (!valid_d[~wr_bank_q]) begin
                  wr_bank_d = ~wr_bank_q;
                  new_d     = 1'b1;
               end else begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.istop) begin
               valid_d = 2'b00;
               state_d = IDLE;
            end else if (accept) begin
               wr_bank_d = rd_bank_q;
               new_d     = 1'b1;
               state_d   = GEN;
            end
         end
         DRAIN: begin
            if (bus.igen_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         state_q   <= IDLE;
         valid_q   <= 2'b00;
         rd_bank_q <= 1'b0;
         wr_bank_q <= 1'b0;
         start_q   <= 1'b0;
         new_q     <= 1'b0;
         cnt_q     <= '0;
         under_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         rd_bank_q <= rd_bank_d;
         wr_bank_q <= wr_bank_d;
         start_q   <= start_d;
         new_q     <= new_d;
         cnt_q     <= cnt_d;
         under_q   <= under_d;
      end
   end
endmodule

// File: tb/tb_otp_bank_scheduler.sv
// Self-checking bench for otp_bank_scheduler: directed scenarios plus
// randomized traffic against a block-counting reference model.
module tb_otp_bank_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   otp_bank_scheduler_if #(.CNT_W(16)) bus();

   otp_bank_scheduler #(.CNT_W(16)) dut (
      .iclk (clk),
      .irst (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Model: blocks are filled and consumed strictly in bank order 0,1,0,1,
   // so banks follow from counts of generated/consumed blocks.
   bit          m_active, m_busy, m_drain, m_under, m_start, m_new;
   int          m_full, m_gens;
   logic [15:0] m_cnt;

   function automatic logic e_ready();
      return logic'(m_active && m_full > 0);
   endfunction

   function automatic logic e_we(input int n);
      return logic'(m_active && m_busy && !m_drain && bus.iwrite_en
                    && (m_gens % 2 == n));
   endfunction

   task automatic model_reset();
      m_active = 0; m_busy = 0; m_drain = 0; m_under = 0;
      m_start = 0; m_new = 0; m_full = 0; m_gens = 0; m_cnt = '0;
   endtask

   task automatic model_step(input bit st, sp, rq, dn);
      bit rdy, acc;
      m_start = 0;
      m_new   = 0;
      rdy     = m_active && m_full > 0;
      if (!sp && rq && !rdy) m_under = 1;
      if (m_drain) begin
         if (dn) begin m_drain = 0; m_busy = 0; end
      end else if (sp) begin
         if (m_active && m_busy) m_drain = 1;
         else m_busy = 0;
         m_active = 0;
         m_full   = 0;
      end else if (!m_active) begin
         if (st) begin
            m_active = 1; m_busy = 1; m_full = 0; m_gens = 0;
            m_cnt = '0; m_under = 0; m_start = 1;
         end
      end else begin
         acc = rq && rdy;
         if (acc) begin m_full--; m_cnt++; end
         if (m_busy) begin
            if (dn) begin
               m_full++;
               m_gens++;
               if (m_full < 2) m_new = 1;
               else m_busy = 0;
            end
         end else if (acc) begin
            m_busy = 1;
            m_new  = 1;
         end
      end
   endtask

   task automatic cycle(input bit st, sp, rq, dn, we);
      @(negedge clk);
      bus.istart     = st;
      bus.istop      = sp;
      bus.iblock_req = rq;
      bus.igen_done  = dn;
      bus.iwrite_en  = we;
      @(posedge clk);
      model_step(st, sp, rq, dn);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.istart = 0; bus.istop = 0; bus.iblock_req = 0;
      bus.igen_done = 0; bus.iwrite_en = 0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_tests++; if (bus.oblock_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", bus.oblock_ready); end
      n_tests++; if (bus.ord_bank !== 1'b0) begin n_fail++; $display("FAIL rst_rd got %b want 0", bus.ord_bank); end
      n_tests++; if (bus.ogen_start !== 1'b0 || bus.ogen_new !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got %b%b want 00", bus.ogen_start, bus.ogen_new); end
      n_tests++; if (bus.oblk_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", bus.oblk_cnt); end
      n_tests++; if (bus.ounderrun !== 1'b0) begin n_fail++; $display("FAIL rst_under got %b want 0", bus.ounderrun); end
   endtask

   task automatic test_start();
      cycle(1, 0, 0, 0, 0);
      n_tests++; if (bus.ogen_start !== 1'b1) begin n_fail++; $display("FAIL start_pulse got %b want 1", bus.ogen_start); end
      cycle(0, 0, 0, 0, 0);
      n_tests++; if (bus.ogen_start !== 1'b0) begin n_fail++; $display("FAIL start_width got %b want 0", bus.ogen_start); end
      cycle(0, 0, 0, 1, 0);
      n_tests++; if (bus.oblock_ready !== 1'b1 || bus.ord_bank !== 1'b0) begin n_fail++; $display("FAIL first_blk ready=%b rd=%b want 1,0", bus.oblock_ready, bus.ord_bank); end
      n_tests++; if (bus.ogen_new !== 1'b1) begin n_fail++; $display("FAIL first_new got %b want 1", bus.ogen_new); end
      cycle(0, 0, 0, 0, 1);
      n_tests++; if (bus.ogen_new !== 1'b0) begin n_fail++; $display("FAIL new_width got %b want 0", bus.ogen_new); end
      n_tests++; if (bus.owrite_en1 !== 1'b1 || bus.owrite_en0 !== 1'b0) begin n_fail++; $display("FAIL wr_bank1 we=%b%b want 10", bus.owrite_en1, bus.owrite_en0); end
   endtask

   task automatic test_hold();
      cycle(0, 0, 0, 1, 1);
      n_tests++; if (bus.ogen_new !== 1'b0) begin n_fail++; $display("FAIL hold_new got %b want 0", bus.ogen_new); end
      n_tests++; if (bus.owrite_en0 !== 1'b0 || bus.owrite_en1 !== 1'b0) begin n_fail++; $display("FAIL hold_we got %b%b want 00", bus.owrite_en1, bus.owrite_en0); end
      cycle(0, 0, 0, 0, 1);
      n_tests++; if (bus.ogen_new !== 1'b0 || bus.owrite_en0 !== 1'b0 || bus.owrite_en1 !== 1'b0) begin n_fail++; $display("FAIL hold_idle new=%b we=%b%b want 0,00", bus.ogen_new, bus.owrite_en1, bus.owrite_en0); end
   endtask

   task automatic test_req_hold();
      cycle(0, 0, 1, 0, 1);
      n_tests++; if (bus.ord_bank !== 1'b1 || bus.oblk_cnt !== 16'd1) begin n_fail++; $display("FAIL hold_req rd=%b cnt=%0d want 1,1", bus.ord_bank, bus.oblk_cnt); end
      n_tests++; if (bus.ogen_new !== 1'b1) begin n_fail++; $display("FAIL hold_req_new got %b want 1", bus.ogen_new); end
      n_tests++; if (bus.owrite_en0 !== 1'b1 || bus.owrite_en1 !== 1'b0) begin n_fail++; $display("FAIL refill_bank0 we=%b%b want 01", bus.owrite_en1, bus.owrite_en0); end
      cycle(0, 0, 0, 0, 0);
      n_tests++; if (bus.owrite_en0 !== 1'b0) begin n_fail++; $display("FAIL we_follow got %b want 0", bus.owrite_en0); end
   endtask

   task automatic test_simultaneous();
      cycle(0, 0, 1, 1, 1);
      n_tests++; if (bus.oblk_cnt !== 16'd2 || bus.ord_bank !== 1'b0) begin n_fail++; $display("FAIL simul_cnt cnt=%0d rd=%b want 2,0", bus.oblk_cnt, bus.ord_bank); end
      n_tests++; if (bus.ogen_new !== 1'b1 || bus.oblock_ready !== 1'b1) begin n_fail++; $display("FAIL simul_gen new=%b ready=%b want 1,1", bus.ogen_new, bus.oblock_ready); end
      n_tests++; if (bus.owrite_en1 !== 1'b1) begin n_fail++; $display("FAIL simul_we1 got %b want 1", bus.owrite_en1); end
   endtask

   task automatic test_underrun();
      cycle(0, 0, 1, 0, 0);
      n_tests++; if (bus.oblk_cnt !== 16'd3 || bus.oblock_ready !== 1'b0 || bus.ounderrun !== 1'b0) begin n_fail++; $display("FAIL drain_last cnt=%0d ready=%b und=%b want 3,0,0", bus.oblk_cnt, bus.oblock_ready, bus.ounderrun); end
      cycle(0, 0, 1, 0, 0);
      n_tests++; if (bus.ounderrun !== 1'b1) begin n_fail++; $display("FAIL underrun got %b want 1", bus.ounderrun); end
      n_tests++; if (bus.oblk_cnt !== 16'd3 || bus.ord_bank !== 1'b1) begin n_fail++; $display("FAIL underrun_hold cnt=%0d rd=%b want 3,1", bus.oblk_cnt, bus.ord_bank); end
      cycle(0, 0, 0, 0, 0);
      n_tests++; if (bus.ounderrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky got %b want 1", bus.ounderrun); end
   endtask

   task automatic test_stop_drain();
      cycle(0, 1, 0, 0, 1);
      n_tests++; if (bus.oblock_ready !== 1'b0 || bus.owrite_en0 !== 1'b0 || bus.owrite_en1 !== 1'b0) begin n_fail++; $display("FAIL drain_gate ready=%b we=%b%b want 0,00", bus.oblock_ready, bus.owrite_en1, bus.owrite_en0); end
      cycle(1, 0, 0, 0, 1);
      n_tests++; if (bus.ogen_start !== 1'b0 || bus.owrite_en1 !== 1'b0) begin n_fail++; $display("FAIL drain_start start=%b we1=%b want 0,0", bus.ogen_start, bus.owrite_en1); end
      cycle(0, 0, 0, 1, 0);
      cycle(1, 0, 0, 0, 0);
      n_tests++; if (bus.ogen_start !== 1'b1 || bus.ounderrun !== 1'b0 || bus.oblk_cnt !== 16'd0) begin n_fail++; $display("FAIL restart start=%b und=%b cnt=%0d want 1,0,0", bus.ogen_start, bus.ounderrun, bus.oblk_cnt); end
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 1);
      n_tests++; if (bus.oblock_ready !== 1'b1 || bus.owrite_en0 !== 1'b0 || bus.owrite_en1 !== 1'b0) begin n_fail++; $display("FAIL rehold ready=%b we=%b%b want 1,00", bus.oblock_ready, bus.owrite_en1, bus.owrite_en0); end
      cycle(0, 0, 1, 0, 1);
      #1 rst = 1'b1;
      #1;
      n_tests++; if (bus.oblock_ready !== 1'b0 || bus.ord_bank !== 1'b0 || bus.oblk_cnt !== 16'd0) begin n_fail++; $display("FAIL async_rst ready=%b rd=%b cnt=%0d want 0,0,0", bus.oblock_ready, bus.ord_bank, bus.oblk_cnt); end
      n_tests++; if (bus.ogen_new !== 1'b0 || bus.owrite_en0 !== 1'b0 || bus.owrite_en1 !== 1'b0) begin n_fail++; $display("FAIL async_rst_out new=%b we=%b%b want 0,00", bus.ogen_new, bus.owrite_en1, bus.owrite_en0); end
      do_reset();
   endtask

   task automatic test_random();
      bit st, sp, rq, dn, we;
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 800; i++) begin
         st = ($urandom_range(0, 15) == 0);
         sp = ($urandom_range(0, 39) == 0);
         rq = ($urandom_range(0, 2) == 0);
         dn = ($urandom_range(0, 3) == 0);
         we = 1'($urandom_range(0, 1));
         cycle(st, sp, rq, dn, we);
         n_tests++; if (bus.oblock_ready !== e_ready()) begin n_fail++; $display("FAIL rnd_ready @%0d got %b want %b", i, bus.oblock_ready, e_ready()); end
         n_tests++; if (bus.ord_bank !== m_cnt[0]) begin n_fail++; $display("FAIL rnd_rd @%0d got %b want %b", i, bus.ord_bank, m_cnt[0]); end
         n_tests++; if (bus.oblk_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt @%0d got %0d want %0d", i, bus.oblk_cnt, m_cnt); end
         n_tests++; if (bus.ogen_start !== m_start || bus.ogen_new !== m_new) begin n_fail++; $display("FAIL rnd_pulse @%0d got %b%b want %b%b", i, bus.ogen_start, bus.ogen_new, m_start, m_new); end
         n_tests++; if (bus.ounderrun !== m_under) begin n_fail++; $display("FAIL rnd_under @%0d got %b want %b", i, bus.ounderrun, m_under); end
         n_tests++; if (bus.owrite_en0 !== e_we(0) || bus.owrite_en1 !== e_we(1)) begin n_fail++; $display("FAIL rnd_we @%0d got %b%b want %b%b", i, bus.owrite_en1, bus.owrite_en0, e_we(1), e_we(0)); end
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_hold();
      test_req_hold();
      test_simultaneous();
      test_underrun();
      test_stop_drain();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
